// File: rtl/mycpu_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, field offsets and load mem_op codes.
package mycpu_pkg;

  localparam int unsigned BUS_3_4_W = 74;
  localparam int unsigned BUS_4_5_W = 70;
  localparam int unsigned FWD_W     = 38;

  // EX->MEM bus: {res_from_mem, mem_op[2:0], rf_we, dest[4:0], alu_result[31:0], pc[31:0]}
  localparam int unsigned B34_PC_LSB   = 0;
  localparam int unsigned B34_ALU_LSB  = 32;
  localparam int unsigned B34_DEST_LSB = 64;
  localparam int unsigned B34_WE_BIT   = 69;
  localparam int unsigned B34_OP_LSB   = 70;
  localparam int unsigned B34_RFM_BIT  = 73;

  // MEM->WB bus: {rf_we, dest[4:0], final_result[31:0], pc[31:0]}
  localparam int unsigned B45_PC_LSB   = 0;
  localparam int unsigned B45_RES_LSB  = 32;
  localparam int unsigned B45_DEST_LSB = 64;
  localparam int unsigned B45_WE_BIT   = 69;

  typedef enum logic [2:0] {
    MEMOP_W  = 3'b000,
    MEMOP_B  = 3'b001,
    MEMOP_H  = 3'b010,
    MEMOP_BU = 3'b101,
    MEMOP_HU = 3'b110
  } mem_op_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment: picks the addressed byte/half from a 32-bit word and sign/zero-extends it.
module load_extend
  import mycpu_pkg::*;
(
  input  logic [2:0]  mem_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Unlisted codes fall back to a full-word load.
  always_comb begin
    ext_o = rdata_i;
    case (mem_op_i)
      MEMOP_B:  ext_o = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_BU: ext_o = {24'd0, byte_sel};
      MEMOP_H:  ext_o = {{16{half_sel[15]}}, half_sel};
      MEMOP_HU: ext_o = {16'd0, half_sel};
      default:  ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_4_mem.sv
// Pipeline stage 4 (MEM): latches the EX payload, collects/buffers the load response and drives WB.
// Optional stall counter enabled by defining MEM_STALL_CNT_EN.
module stage_4_mem
  import mycpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_3,
  output logic                 allow_4,
  input  logic [BUS_3_4_W-1:0] stage_3_to_4,
  input  logic                 allow_5,
  output logic                 valid_4,
  output logic [BUS_4_5_W-1:0] stage_4_to_5,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 data_sram_data_ok,
  output logic [FWD_W-1:0]     fwd_bus,
  output logic                 mem_load_pending,
  output logic [31:0]          mem_stall_cnt
);

  logic                 v4_q, v4_d;
  logic [BUS_3_4_W-1:0] pl_q, pl_d;
  logic                 buf_v_q, buf_v_d;
  logic [31:0]          buf_data_q, buf_data_d;

  logic        res_from_mem, rf_we, readygo, advance;
  logic [2:0]  mem_op;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc, load_data, ext, final_result;

  assign res_from_mem = pl_q[B34_RFM_BIT];
  assign mem_op       = pl_q[B34_OP_LSB +: 3];
  assign rf_we        = pl_q[B34_WE_BIT];
  assign dest         = pl_q[B34_DEST_LSB +: 5];
  assign alu_result   = pl_q[B34_ALU_LSB +: 32];
  assign pc           = pl_q[B34_PC_LSB +: 32];

  assign readygo = ~res_from_mem | data_sram_data_ok | buf_v_q;
  assign advance = v4_q & readygo & allow_5;
  assign allow_4 = ~v4_q | (readygo & allow_5);
  assign valid_4 = v4_q & readygo;

  always_comb begin
    v4_d       = allow_4 ? valid_3 : v4_q;
    pl_d       = (valid_3 & allow_4) ? stage_3_to_4 : pl_q;
    buf_v_d    = buf_v_q;
    buf_data_d = buf_data_q;
    // Hold the response if WB stalls; the SRAM will not repeat it.
    if (advance) begin
      buf_v_d = 1'b0;
    end else if (v4_q & res_from_mem & data_sram_data_ok & ~allow_5 & ~buf_v_q) begin
      buf_v_d    = 1'b1;
      buf_data_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v4_q       <= 1'b0;
      pl_q       <= '0;
      buf_v_q    <= 1'b0;
      buf_data_q <= '0;
    end else begin
      v4_q       <= v4_d;
      pl_q       <= pl_d;
      buf_v_q    <= buf_v_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign load_data = buf_v_q ? buf_data_q : data_sram_rdata;

  load_extend u_load_extend (
    .mem_op_i (mem_op),
    .addr_i   (alu_result[1:0]),
    .rdata_i  (load_data),
    .ext_o    (ext)
  );

  assign final_result = res_from_mem ? ext : alu_result;

  always_comb begin
    stage_4_to_5                         = '0;
    stage_4_to_5[B45_WE_BIT]             = rf_we;
    stage_4_to_5[B45_DEST_LSB +: 5]      = dest;
    stage_4_to_5[B45_RES_LSB +: 32]      = final_result;
    stage_4_to_5[B45_PC_LSB +: 32]       = pc;
  end

  assign fwd_bus          = {v4_q & rf_we, dest, final_result};
  assign mem_load_pending = v4_q & res_from_mem & ~readygo;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v4_q & ~readygo) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign mem_stall_cnt = stall_cnt_q;
`else
  assign mem_stall_cnt = '0;
`endif

endmodule
